// File: rtl/axi_rd_master.sv
// AXI4 read-channel master: splits one user read request into INCR bursts of at most
// MAX_BURST beats, forwards returned data and reports completion plus a sticky error flag.
module axi_rd_master #(
   parameter int         ADDR_WIDTH = 27,
   parameter int         DATA_WIDTH = 16,
   parameter logic [8:0] MAX_BURST  = 9'd8,
   parameter int         ADDR_STEP  = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  init_end,
   input  logic                  rd_trig,
   input  logic [7:0]            rd_len,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_valid,
   output logic                  rd_ready,
   output logic                  rd_done,
   output logic                  rd_err,
   output logic                  axi_arvalid,
   input  logic                  axi_arready,
   output logic [ADDR_WIDTH-1:0] axi_araddr,
   output logic [7:0]            axi_arlen,
   input  logic                  axi_rvalid,
   output logic                  axi_rready,
   input  logic [DATA_WIDTH-1:0] axi_rdata,
   input  logic [1:0]            axi_rresp,
   input  logic                  axi_rlast
);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

   state_t                r_state;
   logic [8:0]            r_remaining;
   logic [7:0]            r_beat_cnt;
   logic [ADDR_WIDTH-1:0] r_cur_addr;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [7:0]            r_arlen;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_err;

   logic [8:0]            w_req_beats;
   logic [8:0]            w_burst_beats;
   logic [8:0]            w_rem_after;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic                  w_beat;
   logic                  w_beat_err;

   // Burst length field for a given number of outstanding beats (min taken on 9 bits).
   function automatic logic [7:0] f_arlen(input logic [8:0] beats);
      logic [8:0] n;
      n = (beats < MAX_BURST) ? beats : MAX_BURST;
      n = n - 9'd1;
      return n[7:0];
   endfunction

   assign w_req_beats   = {1'b0, rd_len} + 9'd1;
   assign w_burst_beats = {1'b0, r_arlen} + 9'd1;
   assign w_rem_after   = r_remaining - w_burst_beats;
   assign w_next_addr   = r_cur_addr + ADDR_WIDTH'(w_burst_beats) * ADDR_WIDTH'(ADDR_STEP);
   assign w_beat        = axi_rvalid & r_rready;
   assign w_beat_err    = (axi_rresp != 2'b00) ||
                          (axi_rlast && (r_beat_cnt != 8'd0)) ||
                          (!axi_rlast && (r_beat_cnt == 8'd0));

   assign rd_data       = axi_rdata;
   assign rd_data_valid = w_beat;
   assign rd_ready      = (r_state == S_IDLE);
   assign rd_done       = (r_state == S_DONE);
   assign rd_err        = r_err;
   assign axi_arvalid   = r_arvalid;
   assign axi_araddr    = r_araddr;
   assign axi_arlen     = r_arlen;
   assign axi_rready    = r_rready;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_remaining <= 9'd0;
         r_beat_cnt  <= 8'd0;
         r_cur_addr  <= '0;
         r_araddr    <= '0;
         r_arlen     <= 8'd0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (rd_trig && init_end) begin
                  r_cur_addr  <= rd_addr;
                  r_araddr    <= rd_addr;
                  r_remaining <= w_req_beats;
                  r_arlen     <= f_arlen(w_req_beats);
                  r_err       <= 1'b0;
                  r_arvalid   <= 1'b1;
                  r_state     <= S_AR;
               end
            end
            S_AR: begin
               if (axi_arready) begin
                  r_arvalid  <= 1'b0;
                  r_rready   <= 1'b1;
                  r_beat_cnt <= r_arlen;
                  r_state    <= S_R;
               end
            end
            S_R: begin
               // Exactly arlen+1 beats are taken regardless of where rlast shows up.
               if (w_beat) begin
                  if (w_beat_err) begin
                     r_err <= 1'b1;
                  end
                  if (r_beat_cnt == 8'd0) begin
                     r_remaining <= w_rem_after;
                     r_rready    <= 1'b0;
                     if (w_rem_after == 9'd0) begin
                        r_state <= S_DONE;
                     end else begin
                        r_cur_addr <= w_next_addr;
                        r_araddr   <= w_next_addr;
                        r_arlen    <= f_arlen(w_rem_after);
                        r_arvalid  <= 1'b1;
                        r_state    <= S_AR;
                     end
                  end else begin
                     r_beat_cnt <= r_beat_cnt - 8'd1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rd_master.sv
// Randomized bench for axi_rd_master: a slave model answers AR/R and every observation
// is compared against burst lists and error expectations derived from the request itself.
module tb_axi_rd_master;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        init_end = 1'b1;
   logic        rd_trig = 1'b0;
   logic [7:0]  rd_len = 8'd0;
   logic [26:0] rd_addr = '0;
   logic [15:0] rd_data;
   logic        rd_data_valid;
   logic        rd_ready;
   logic        rd_done;
   logic        rd_err;
   logic        axi_arvalid;
   logic        axi_arready = 1'b0;
   logic [26:0] axi_araddr;
   logic [7:0]  axi_arlen;
   logic        axi_rvalid = 1'b0;
   logic        axi_rready;
   logic [15:0] axi_rdata = '0;
   logic [1:0]  axi_rresp = 2'b00;
   logic        axi_rlast = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_rd_master dut (
      .clk(clk), .rstn(rstn), .init_end(init_end), .rd_trig(rd_trig), .rd_len(rd_len),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_ready(rd_ready),
      .rd_done(rd_done), .rd_err(rd_err), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_rvalid(axi_rvalid),
      .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One complete request: build the expected AR list, act as slave, check everything.
   task automatic run_req(input logic [26:0] addr, input logic [7:0] len, input int ar_delay,
                          input int gap_pct, input int emode, input bit poke);
      logic [26:0] exp_addr_q[$];
      logic [7:0]  exp_len_q[$];
      bit          exp_last[256];
      logic [26:0] a;
      logic [26:0] held_addr;
      logic [7:0]  held_len;
      int          rem, n, idx, total, nbeat, waitc, bad_idx, nars;
      bit          exp_err, done;

      total = int'(len) + 1;
      rem = total;
      a = addr;
      idx = 0;
      while (rem > 0) begin
         n = (rem < 8) ? rem : 8;
         exp_addr_q.push_back(a);
         exp_len_q.push_back(8'(n - 1));
         for (int k = 0; k < n; k++) exp_last[idx + k] = (k == n - 1);
         idx += n;
         a = a + 27'(n * 2);
         rem -= n;
      end
      nars = exp_addr_q.size();
      bad_idx = $urandom_range(total - 1);
      exp_err = (emode == 1 && total > 2) || (emode == 2);
      held_addr = '0;
      held_len = '0;

      @(negedge clk);
      chk("idle_ready", 32'(rd_ready), 1);
      rd_addr = addr;
      rd_len = len;
      rd_trig = 1'b1;
      @(negedge clk);
      rd_trig = 1'b0;
      chk("ar_latency", 32'(axi_arvalid), 1);
      chk("err_cleared", 32'(rd_err), 0);

      nbeat = 0;
      waitc = 0;
      done = 1'b0;
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
         if (nbeat == total) begin
            axi_rvalid = 1'b0;
            axi_arready = 1'b0;
            rd_trig = 1'b0;
            chk("done_pulse", 32'(rd_done), 1);
            chk("done_err", 32'(rd_err), 32'(exp_err));
            chk("done_rready", 32'(axi_rready), 0);
            chk("ar_count", 32'(exp_addr_q.size()), 0);
            @(negedge clk);
            chk("done_once", 32'(rd_done), 0);
            chk("back_idle", 32'(rd_ready), 1);
            chk("no_extra_ar", 32'(axi_arvalid), 0);
            chk("err_held", 32'(rd_err), 32'(exp_err));
            done = 1'b1;
         end else begin
            chk("busy_ready", 32'(rd_ready), 0);
            chk("done_early", 32'(rd_done), 0);
            chk("ar_r_overlap", 32'(axi_arvalid & axi_rready), 0);
            if (axi_arvalid) begin
               if (waitc == 0) begin
                  if (exp_addr_q.size() == 0) begin
                     chk("extra_ar", 32'(nars + 1), 32'(nars));
                  end else begin
                     held_addr = exp_addr_q.pop_front();
                     held_len = exp_len_q.pop_front();
                     chk("araddr", 32'(axi_araddr), 32'(held_addr));
                     chk("arlen", 32'(axi_arlen), 32'(held_len));
                  end
               end else begin
                  chk("araddr_stable", 32'(axi_araddr), 32'(held_addr));
                  chk("arlen_stable", 32'(axi_arlen), 32'(held_len));
               end
               axi_arready = (waitc >= ar_delay);
               waitc++;
            end else begin
               axi_arready = 1'b0;
               waitc = 0;
            end
            if (axi_rready) begin
               axi_rvalid = ($urandom_range(99) >= gap_pct);
               axi_rdata = 16'($urandom);
               axi_rlast = exp_last[nbeat] ^ (emode == 1 && nbeat == 2);
               axi_rresp = (emode == 2 && nbeat == bad_idx) ? 2'b10 : 2'b00;
            end else begin
               axi_rvalid = 1'b0;
            end
            rd_trig = poke && axi_rready && (nbeat == 1);
            #1;
            chk("beat_valid", 32'(rd_data_valid), 32'(axi_rvalid & axi_rready));
            if (axi_rvalid && axi_rready) begin
               chk("rd_data", 32'(rd_data), 32'(axi_rdata));
               nbeat++;
            end
            @(negedge clk);
         end
      end
      rd_trig = 1'b0;
      if (!done) chk("timeout", 0, 1);
      $display("req addr=0x%07h len=%0d ars=%0d err=%0d beats=%0d", addr, len, nars, exp_err, nbeat);
   endtask

   initial begin
      int ok;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("rst_arvalid", 32'(axi_arvalid), 0);
      chk("rst_araddr", 32'(axi_araddr), 0);
      chk("rst_arlen", 32'(axi_arlen), 0);
      chk("rst_rready", 32'(axi_rready), 0);
      chk("rst_err", 32'(rd_err), 0);
      chk("rst_ready", 32'(rd_ready), 1);
      chk("rst_done", 32'(rd_done), 0);

      run_req(27'h100, 8'd7, 0, 0, 0, 1'b0);
      run_req(27'h000, 8'd19, 0, 0, 0, 1'b0);
      run_req(27'h4000, 8'd30, 5, 35, 0, 1'b0);
      run_req(27'h200, 8'd7, 0, 20, 1, 1'b0);
      run_req(27'h240, 8'd7, 0, 0, 0, 1'b0);
      run_req(27'h280, 8'd7, 1, 10, 2, 1'b0);
      run_req(27'h300, 8'd12, 1, 10, 0, 1'b1);

      // Request while DDR init is not complete must not start anything.
      init_end = 1'b0;
      @(negedge clk);
      rd_addr = 27'h500;
      rd_len = 8'd3;
      rd_trig = 1'b1;
      @(negedge clk);
      rd_trig = 1'b0;
      repeat (3) @(negedge clk);
      chk("noinit_arvalid", 32'(axi_arvalid), 0);
      chk("noinit_ready", 32'(rd_ready), 1);
      init_end = 1'b1;

      run_req(27'h7FFFFF8, 8'd15, 0, 0, 0, 1'b0);
      run_req(27'h7FFFFF0, 8'd255, 2, 15, 0, 1'b0);
      run_req(27'h20, 8'd0, 0, 0, 0, 1'b0);

      for (int t = 0; t < 20; t++) begin
         run_req(27'($urandom) & ~27'h1, 8'($urandom_range(70)), $urandom_range(4),
                 $urandom_range(40), $urandom_range(2), 1'($urandom_range(1)));
      end

      // Reset while data beats are being accepted.
      @(negedge clk);
      rd_addr = 27'h800;
      rd_len = 8'd15;
      rd_trig = 1'b1;
      @(negedge clk);
      rd_trig = 1'b0;
      axi_arready = 1'b1;
      ok = 0;
      for (int c = 0; c < 20 && ok == 0; c++) begin
         @(negedge clk);
         axi_arready = 1'b0;
         if (axi_rready) ok = 1;
      end
      chk("rst_mid_reach_r", 32'(ok), 1);
      axi_rvalid = 1'b1;
      axi_rlast = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_arvalid", 32'(axi_arvalid), 0);
      chk("midrst_rready", 32'(axi_rready), 0);
      chk("midrst_ready", 32'(rd_ready), 1);
      axi_rvalid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      run_req(27'h900, 8'd9, 0, 10, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
